// File: rtl/gpio_pkg.sv
// Shared constants and types for the board GPIO AHB-Lite slave.
//   - GPIO_OFS_*      : word indices (haddr[4:2]) of the register map
//   - gpio_err_state_e: two-cycle AHB ERROR response sequencer states
//   - HSIZE_WORD      : the only legal write size
package gpio_pkg;

  localparam logic [2:0] GPIO_OFS_SOC_ID    = 3'd0;
  localparam logic [2:0] GPIO_OFS_BLD_ID    = 3'd1;
  localparam logic [2:0] GPIO_OFS_CLK_FREQ  = 3'd2;
  localparam logic [2:0] GPIO_OFS_LED       = 3'd3;
  localparam logic [2:0] GPIO_OFS_BTN_STATE = 3'd4;
  localparam logic [2:0] GPIO_OFS_BTN_EVT   = 3'd5;
  localparam logic [2:0] GPIO_OFS_IRQ_EN    = 3'd6;
  localparam logic [2:0] GPIO_OFS_RSVD      = 3'd7;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } gpio_err_state_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single push-button debouncer.
//   clk, rst : core clock, synchronous active-high reset
//   raw_i    : raw asynchronous button level
//   state_o  : accepted (debounced) level, 1 = pressed
//   rise_o   : one-cycle pulse, asserted in the cycle whose closing edge
//              sets state_o from 0 to 1
module gpio_debounce #(
  parameter int CYCLES     = 135_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic state_o,
  output logic rise_o
);

  localparam int             CW       = $clog2(CYCLES);
  localparam logic [CW-1:0]  LAST     = CW'(CYCLES - 1);
  // Synchronizer resets to the released level so that leaving reset does
  // not look like a press.
  localparam logic           REL_LVL  = (ACTIVE_LOW != 0);

  logic          s1_q, s2_q;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          synced;
  logic          expire;

  assign synced = s2_q ^ REL_LVL;
  assign expire = (synced != acc_q) && (cnt_q == LAST);

  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (synced != acc_q) begin
      if (cnt_q == LAST) acc_d = ~acc_q;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= REL_LVL;
      s2_q  <= REL_LVL;
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign state_o = acc_q;
  assign rise_o  = expire & synced;

endmodule

// File: rtl/ahb_lite_board_gpio.sv
// AHB-Lite board GPIO slave: identity constants, LEDs, debounced buttons
// with W1C press events and a level interrupt.
//   AHB side : hsel, haddr, htrans, hsize, hwrite, hwdata, hready_in in;
//              hrdata, hready (readyout), hresp out. Zero-wait reads and
//              writes; illegal accesses get a two-cycle ERROR.
//   Board    : btn_i raw buttons in, led_o LED drive out
//   irq      : registered |(BTN_EVT & IRQ_EN)
module ahb_lite_board_gpio
  import gpio_pkg::*;
#(
  parameter logic [31:0] SOC_ID          = 32'h0,
  parameter logic [31:0] BLD_ID          = 32'h0,
  parameter logic [31:0] CLK_FREQ        = 32'd27_000_000,
  parameter int          N_LED           = 6,
  parameter int          N_BTN           = 5,
  parameter int          DEBOUNCE_CYCLES = 135_000,
  parameter int          BTN_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsel,
  input  logic [31:0]      haddr,
  input  logic [1:0]       htrans,
  input  logic [2:0]       hsize,
  input  logic             hwrite,
  input  logic [31:0]      hwdata,
  input  logic             hready_in,
  output logic [31:0]      hrdata,
  output logic             hready,
  output logic             hresp,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_LED-1:0] led_o,
  output logic             irq
);

  gpio_err_state_e  state_q, state_d;
  logic             wr_pend_q;
  logic [2:0]       wr_ofs_q;
  logic [31:0]      hrdata_q, hrdata_d, rd_word;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_BTN-1:0] en_q, en_d, evt_q, evt_d;
  logic             irq_q;
  logic [N_BTN-1:0] btn_state, btn_rise;
  logic [2:0]       a_ofs;
  logic             accept, ro_ofs, err;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    gpio_debounce #(
      .CYCLES    (DEBOUNCE_CYCLES),
      .ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (btn_i[i]),
      .state_o(btn_state[i]),
      .rise_o (btn_rise[i])
    );
  end

  // hready_in is already low in ERR1 on a real bus; the state check keeps
  // the slave safe if it is not.
  assign a_ofs  = haddr[4:2];
  assign accept = hsel && htrans[1] && hready_in && (state_q != ERR1);
  assign ro_ofs = (a_ofs == GPIO_OFS_SOC_ID) || (a_ofs == GPIO_OFS_BLD_ID) ||
                  (a_ofs == GPIO_OFS_CLK_FREQ) || (a_ofs == GPIO_OFS_BTN_STATE);
  assign err    = (a_ofs == GPIO_OFS_RSVD) ||
                  (hwrite && (ro_ofs || (hsize != HSIZE_WORD)));

  // Register next-state. The read mux below uses these _d values, which
  // gives the write-then-read bypass for free.
  always_comb begin
    led_d = led_q;
    en_d  = en_q;
    evt_d = evt_q;
    if (wr_pend_q) begin
      case (wr_ofs_q)
        GPIO_OFS_LED:     led_d = hwdata[N_LED-1:0];
        GPIO_OFS_BTN_EVT: evt_d = evt_q & ~hwdata[N_BTN-1:0];
        GPIO_OFS_IRQ_EN:  en_d  = hwdata[N_BTN-1:0];
        default: ;
      endcase
    end
    evt_d = evt_d | btn_rise;  // a new press beats a same-cycle clear
  end

  always_comb begin
    rd_word = '0;
    case (a_ofs)
      GPIO_OFS_SOC_ID:    rd_word = SOC_ID;
      GPIO_OFS_BLD_ID:    rd_word = BLD_ID;
      GPIO_OFS_CLK_FREQ:  rd_word = CLK_FREQ;
      GPIO_OFS_LED:       rd_word[N_LED-1:0] = led_d;
      GPIO_OFS_BTN_STATE: rd_word[N_BTN-1:0] = btn_state;
      GPIO_OFS_BTN_EVT:   rd_word[N_BTN-1:0] = evt_d;
      GPIO_OFS_IRQ_EN:    rd_word[N_BTN-1:0] = en_d;
      default:            rd_word = '0;
    endcase
    hrdata_d = hrdata_q;
    if (accept && !hwrite) hrdata_d = err ? '0 : rd_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ERR1:    state_d = ERR2;
      default: state_d = (accept && err) ? ERR1 : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_pend_q <= 1'b0;
      wr_ofs_q  <= '0;
      hrdata_q  <= '0;
      led_q     <= '0;
      en_q      <= '0;
      evt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= accept && hwrite && !err;
      wr_ofs_q  <= a_ofs;
      hrdata_q  <= hrdata_d;
      led_q     <= led_d;
      en_q      <= en_d;
      evt_q     <= evt_d;
      irq_q     <= |(evt_q & en_q);
    end
  end

  assign hrdata = hrdata_q;
  assign hready = (state_q != ERR1);
  assign hresp  = (state_q != IDLE);
  assign led_o  = led_q;
  assign irq    = irq_q;

  logic unused_bits;
  assign unused_bits = ^{haddr[31:5], haddr[1:0], htrans[0], hwdata};

endmodule

// File: tb/tb_ahb_lite_board_gpio.sv
// Randomized + directed bench for ahb_lite_board_gpio. A reference model
// advanced once per clock pushes expected per-cycle outputs and expected
// read data into queues; a negedge monitor pops and compares.
module tb_ahb_lite_board_gpio;

  localparam logic [31:0] SOC = 32'hCAFE_0001;
  localparam logic [31:0] BLD = 32'h1234_5678;
  localparam logic [31:0] FRQ = 32'd27_000_000;
  localparam int D  = 4;
  localparam int HL = D + 2;

  logic        clk = 1'b0, rst;
  logic        hsel, hwrite, hready_in, hready, hresp, irq;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [4:0]  btn_i;
  logic [5:0]  led_o;

  ahb_lite_board_gpio #(
    .SOC_ID(SOC), .BLD_ID(BLD), .CLK_FREQ(FRQ), .N_LED(6), .N_BTN(5),
    .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .btn_i(btn_i),
    .led_o(led_o), .irq(irq)
  );

  always #5 clk = ~clk;
  assign hready_in = hready;  // single-slave bus

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct {
    bit         rst;
    logic       hready, hresp, irq;
    logic [5:0] led;
  } cyc_t;
  cyc_t        q_cyc[$];
  logic [31:0] q_rd[$];

  // ---------------- reference model ----------------
  logic [4:0] m_hist [HL];  // pressed levels sampled k edges ago
  logic [5:0] m_led;
  logic [4:0] m_en, m_evt, m_acc;
  logic       m_irq;
  int         m_err_left;   // remaining ERROR response cycles
  bit         m_wp;
  logic [2:0] m_wofs;

  function automatic bit is_err(input bit wr, input logic [2:0] ofs, input logic [2:0] sz);
    return (ofs == 3'd7) || (wr && (ofs == 3'd0 || ofs == 3'd1 || ofs == 3'd2 ||
                                    ofs == 3'd4 || sz != 3'b010));
  endfunction

  task automatic model_step();
    cyc_t c; logic [4:0] acc_old; logic irq_nx; bit acc, er, in_err1, stable;
    logic [2:0] ofs; logic [31:0] rv;
    if (rst) begin
      m_led = '0; m_en = '0; m_evt = '0; m_acc = '0; m_irq = 0;
      m_err_left = 0; m_wp = 0; m_wofs = '0;
      for (int k = 0; k < HL; k++) m_hist[k] = '0;
      c.rst = 1; c.hready = 1; c.hresp = 0; c.irq = 0; c.led = '0;
      q_cyc.push_back(c);
      return;
    end
    irq_nx = |(m_evt & m_en);
    if (m_wp) begin
      case (m_wofs)
        3'd3: m_led = hwdata[5:0];
        3'd5: m_evt = m_evt & ~hwdata[4:0];
        3'd6: m_en  = hwdata[4:0];
        default: ;
      endcase
    end
    // A button's level is accepted once D consecutive samples, two edges
    // old (synchronizer), all disagree with the current accepted level.
    for (int k = HL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = ~btn_i;
    acc_old = m_acc;
    for (int b = 0; b < 5; b++) begin
      stable = 1;
      for (int k = 2; k < HL; k++) if (m_hist[k][b] == m_acc[b]) stable = 0;
      if (stable) begin
        m_acc[b] = ~m_acc[b];
        if (m_acc[b]) m_evt[b] = 1'b1;
      end
    end
    in_err1 = (m_err_left == 2);
    m_err_left = (m_err_left > 0) ? m_err_left - 1 : 0;
    ofs = haddr[4:2];
    acc = hsel && htrans[1] && !in_err1;
    er  = is_err(hwrite, ofs, hsize);
    m_wp = acc && hwrite && !er;
    m_wofs = ofs;
    if (acc && er) m_err_left = 2;
    if (acc && !hwrite && !er) begin
      case (ofs)
        3'd0: rv = SOC;
        3'd1: rv = BLD;
        3'd2: rv = FRQ;
        3'd3: rv = {26'd0, m_led};
        3'd4: rv = {27'd0, acc_old};
        3'd5: rv = {27'd0, m_evt};
        default: rv = {27'd0, m_en};
      endcase
      q_rd.push_back(rv);
    end
    m_irq = irq_nx;
    c.rst = 0; c.hready = (m_err_left != 2); c.hresp = (m_err_left != 0);
    c.led = m_led; c.irq = m_irq;
    q_cyc.push_back(c);
  endtask

  // ---------------- monitor ----------------
  logic rd_dp = 1'b0;
  always @(posedge clk) rd_dp <= !rst && hsel && htrans[1] && hready_in && !hwrite;

  always @(negedge clk) begin
    cyc_t c;
    if (q_cyc.size() > 0) begin
      c = q_cyc.pop_front();
      chk("hready", {31'd0, hready}, {31'd0, c.hready});
      chk("hresp",  {31'd0, hresp},  {31'd0, c.hresp});
      chk("led_o",  {26'd0, led_o},  {26'd0, c.led});
      chk("irq",    {31'd0, irq},    {31'd0, c.irq});
      if (c.rst) chk("hrdata_rst", hrdata, 32'd0);
    end
    if (rd_dp && hready && !hresp) begin
      if (q_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                  chk("hrdata", hrdata, q_rd.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wdat_nxt = '0;
  bit          rnd_btn = 0;

  task automatic tick();
    if (rnd_btn && $urandom_range(0, 5) == 0) btn_i[$urandom_range(0, 4)] ^= 1'b1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input bit sel, input logic [1:0] tr, input bit wr,
                           input logic [2:0] ofs, input logic [2:0] sz, input logic [31:0] wd);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz;
    haddr = ($urandom() & 32'hFFFF_FFE3) | {27'd0, ofs, 2'b00};
    hwdata = wdat_nxt;
    wdat_nxt = wd;
    tick();
  endtask

  // Erroring transfers get an IDLE during ERR1, as a master would drive.
  task automatic xfer(input bit wr, input logic [2:0] ofs, input logic [2:0] sz, input logic [31:0] wd);
    bus_cycle(1'b1, $urandom_range(0, 1) ? 2'b10 : 2'b11, wr, ofs, sz, wd);
    if (is_err(wr, ofs, sz)) bus_cycle(1'b0, 2'b00, 1'b0, 3'd0, 3'b010, $urandom());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      bus_cycle($urandom_range(0, 1), $urandom_range(0, 1) ? 2'b01 : 2'b00,
                $urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'b010, $urandom());
  endtask

  initial begin
    rst = 1; btn_i = '1; hsel = 0; htrans = 0; hwrite = 0; hsize = 3'b010;
    haddr = 0; hwdata = 0;
    repeat (3) tick();
    rst = 0;
    // identity registers, assorted read sizes
    xfer(0, 3'd0, 3'b010, 0); xfer(0, 3'd1, 3'b000, 0); xfer(0, 3'd2, 3'b001, 0);
    idle(1);
    // write then back-to-back read of LED
    xfer(1, 3'd3, 3'b010, 32'h2A); xfer(0, 3'd3, 3'b010, 0); idle(2);
    // glitchy press on button 2 with IRQ_EN bit 2 set
    xfer(1, 3'd6, 3'b010, 32'h4); idle(1);
    btn_i[2] = 0; idle(1); btn_i[2] = 1; idle(1); btn_i[2] = 0; idle(1); btn_i[2] = 1; idle(1);
    btn_i[2] = 0;
    repeat (8) xfer(0, 3'd4, 3'b010, 0);
    xfer(0, 3'd5, 3'b010, 0); idle(2);
    // release, re-press, and clear bit 2 on the edge the new press lands
    btn_i[2] = 1; idle(8);
    btn_i[2] = 0; idle(4);
    xfer(1, 3'd5, 3'b010, 32'h4); idle(1);
    xfer(0, 3'd5, 3'b010, 0); idle(1);
    xfer(1, 3'd5, 3'b010, 32'h4); idle(1);
    xfer(0, 3'd5, 3'b010, 0); idle(2);
    // error responses; LED must survive
    xfer(1, 3'd0, 3'b010, 32'hFFFF_FFFF); xfer(0, 3'd7, 3'b010, 0);
    xfer(1, 3'd3, 3'b000, 32'h15); xfer(0, 3'd3, 3'b010, 0); idle(1);
    // reset in ERR1 with LEDs lit and an event pending
    xfer(1, 3'd3, 3'b010, 32'h3F);
    btn_i[2] = 1; idle(8); btn_i[2] = 0; idle(8);
    bus_cycle(1'b1, 2'b10, 1'b1, 3'd0, 3'b010, 0);
    btn_i = '1; rst = 1;
    bus_cycle(1'b0, 2'b00, 1'b0, 3'd0, 3'b010, 0);
    rst = 0;
    idle(1); xfer(0, 3'd5, 3'b010, 0); xfer(0, 3'd3, 3'b010, 0); idle(1);
    // randomized traffic with random button activity
    rnd_btn = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 6)
        xfer($urandom_range(0, 1), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b010, $urandom());
      else
        idle(1);
    end
    rnd_btn = 0;
    idle(4);
    @(negedge clk); #1;
    chk("q_rd_drained", q_rd.size(), 0);
    chk("q_cyc_drained", q_cyc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
